hd08_bit_deser: RTL and testbench
=================================

# hd08_bit_deser

Serial-to-parallel front-end stage that assembles an LSB-first bit stream into 8-bit words and presents them as the parallel operand vector x0..x7 to the hd08 predicate stage directly downstream. It holds each completed word stable under a valid/ready handshake, buffers up to two words, and counts words dropped on overflow. Framing is resynchronised by a start-of-frame marker.

## Interface
- `DROP_W`, default 8: width of the saturating drop counter.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `s_bit  in  1`: serial data bit.
- `s_valid  in  1`: `s_bit` is valid this cycle. There is no backpressure on the serial side.
- `s_sof  in  1`: qualified by `s_valid`; marks this bit as bit 0 of a new frame.
- `m_x  out  8`: parallel word; `m_x[i]` drives predicate input `xi`.
- `m_valid  out  1`: `m_x` holds a complete word.
- `m_ready  in  1`: downstream accepts the word this cycle.
- `m_perr  out  1`: parity error flag for the word on `m_x`. Present only with `HD08_DESER_PARITY_EN`.
- `drop_cnt  out  DROP_W`: number of words lost to overflow, saturating.

## Operation
- The frame assembler has three states: IDLE, COLLECT, and PAR (PAR is used only with parity enabled).
- Bits are stored LSB-first: the k-th valid bit of a frame goes to shift position k, and the word becomes `m_x[k]`.
- Transitions:
  - IDLE goes to COLLECT on any `s_valid`.
  - COLLECT increments the bit counter (0..7) on each `s_valid`.
  - After the 8th bit, the assembler goes to PAR if parity is enabled, otherwise it completes the word and returns to IDLE.
  - PAR consumes one `s_valid` bit, completes the word, and returns to IDLE.
- `s_valid & s_sof` in any state discards any partial word. That bit is taken as bit 0, and the assembler goes to COLLECT with the counter at 1. No drop is counted.
- Buffering uses two entries: an output register (OUT) feeding `m_x`, `m_valid`, `m_perr`, and a skid register (SKID).
- When a word completes:
  - OUT empty, or OUT draining this cycle with SKID empty: the word loads into OUT.
  - OUT full and not draining, SKID empty: the word loads into SKID.
  - OUT draining and SKID full: SKID moves to OUT and the new word loads into SKID.
  - OUT and SKID both full and OUT not draining: the new word is discarded and `drop_cnt` increments, saturating at 2^DROP_W−1.
- A handshake occurs when `m_valid & m_ready`. On that edge OUT either reloads from SKID or becomes empty.
- `m_x` and `m_perr` must stay stable while `m_valid=1` and `m_ready=0`.
- Ordering is strict FIFO. Words are never reordered or duplicated.

## Timing
- Reset values: `m_x=8'h00`, `m_valid=0`, `m_perr=0`, `drop_cnt=0`, state IDLE, counter 0, SKID empty.
- Reset asserted mid-frame or with words buffered discards everything immediately (asynchronous). The first `s_valid` after release is bit 0 regardless of `s_sof`.
- Latency: the last bit of a frame is accepted at edge t. With OUT empty, `m_valid=1` after edge t, so it is visible in cycle t+1.
- Throughput is one word per 8 bits, or 9 with parity. The buffer never limits the serial rate while `m_ready` is held high.
- Gaps in `s_valid` stall assembly without loss.
- `m_valid` falls on the edge after the handshake unless SKID was full, in which case it stays high with the next word.

## Configuration
- `HD08_DESER_PARITY_EN` defined:
  - Each frame is 9 bits: 8 data bits plus an even-parity bit.
  - `m_perr=1` when the XOR of the 8 data bits and the parity bit is 1.
  - A word with a parity error is still delivered; `m_perr` travels with it through SKID.
- Not defined:
  - Frames are 8 bits, the PAR state and `m_perr` port do not exist, and no parity logic is generated.

## Test plan
- Reset, then bits 1,0,1,1,0,0,0,1 (`s_sof` on the first) with `m_ready=1`: `m_x=8'h8D`, `m_valid` high for exactly one cycle, starting the cycle after the 8th bit.
- `m_ready=0`, send 3 words 8'h01, 8'h02, 8'h03: first two words are held with `m_x` stable at 8'h01, `drop_cnt=1`. Then raise `m_ready`: handshakes yield 8'h01, then 8'h02, then `m_valid=0`.
- Send 5 bits, then `s_sof` and a full word 8'hA5: only 8'hA5 is delivered, and `drop_cnt` is unchanged.
- Insert random `s_valid` gaps inside the word 8'h3C: 8'h3C is delivered with no loss or reordering.
- Assert `rst` asynchronously mid-frame with OUT and SKID full: all outputs return to reset values before the next edge, and the next frame decodes correctly.
- With `HD08_DESER_PARITY_EN`, send data 8'h07 with parity bit 1 (then a second frame with parity bit 0): `m_perr=0` for the first frame and `m_perr=1` for the second, both words delivered as 8'h07.

Source files
------------

// File: rtl/hd08_bit_deser.sv
// Purpose: LSB-first serial-to-parallel assembler feeding x0..x7 of the hd08 predicate stage (optional parity: HD08_DESER_PARITY_EN).
// Latency: word visible on m_x/m_valid the cycle after its last serial bit (data bit 7, or the parity bit).
// Backpressure: two-entry OUT+SKID buffer; serial side never stalls, a word completing with both entries held is dropped and counted.
module hd08_bit_deser #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_bit,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic [7:0]        m_x,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef HD08_DESER_PARITY_EN
    output logic              m_perr,
`endif
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef HD08_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic       wr_vld;
    logic [7:0] wr_dat;

    logic [7:0] skid_dat;
    logic       skid_vld;
    logic       drain;

`ifdef HD08_DESER_PARITY_EN
    logic       wr_perr;
    logic       skid_perr;
`endif

    // Frame assembler state and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            shift <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shift <= shift_nxt;
        end
    end

    // Next-state logic: sof (or the first bit out of IDLE) restarts the word at bit 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        wr_vld    = 1'b0;
`ifdef HD08_DESER_PARITY_EN
        wr_perr   = 1'b0;
`endif
        if (s_valid) begin
            if (s_sof || state == IDLE) begin
                shift_nxt = {7'd0, s_bit};
                cnt_nxt   = 3'd1;
                state_nxt = COLLECT;
            end else if (state == COLLECT) begin
                shift_nxt[cnt] = s_bit;
                // Wraps to 0 after bit 7, ready for the next frame.
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
`ifdef HD08_DESER_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = IDLE;
                    wr_vld    = 1'b1;
`endif
                end
            end
`ifdef HD08_DESER_PARITY_EN
            else begin
                // PAR: even parity over 8 data bits plus the parity bit.
                state_nxt = IDLE;
                wr_vld    = 1'b1;
                wr_perr   = (^shift) ^ s_bit;
            end
`endif
        end
    end

    // Completed word is the updated shift contents (unchanged in PAR).
    assign wr_dat = shift_nxt;
    assign drain  = m_valid & m_ready;

    // OUT/SKID buffer: strict FIFO order, drop only when both held and OUT not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_x       <= 8'h00;
            m_valid   <= 1'b0;
            skid_dat  <= 8'h00;
            skid_vld  <= 1'b0;
            drop_cnt  <= '0;
`ifdef HD08_DESER_PARITY_EN
            m_perr    <= 1'b0;
            skid_perr <= 1'b0;
`endif
        end else if (wr_vld) begin
            if (!m_valid || (drain && !skid_vld)) begin
                m_x     <= wr_dat;
                m_valid <= 1'b1;
`ifdef HD08_DESER_PARITY_EN
                m_perr  <= wr_perr;
`endif
            end else if (!drain && !skid_vld) begin
                skid_dat  <= wr_dat;
                skid_vld  <= 1'b1;
`ifdef HD08_DESER_PARITY_EN
                skid_perr <= wr_perr;
`endif
            end else if (drain) begin
                m_x       <= skid_dat;
                skid_dat  <= wr_dat;
`ifdef HD08_DESER_PARITY_EN
                m_perr    <= skid_perr;
                skid_perr <= wr_perr;
`endif
            end else if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (drain) begin
            if (skid_vld) begin
                m_x      <= skid_dat;
                skid_vld <= 1'b0;
`ifdef HD08_DESER_PARITY_EN
                m_perr   <= skid_perr;
`endif
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hd08_bit_deser.sv
module tb_hd08_bit_deser;

`ifdef HD08_DESER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_bit = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_sof = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_x;
    logic       m_valid;
    logic [7:0] drop_cnt;
`ifdef HD08_DESER_PARITY_EN
    logic       m_perr;
`else
    logic       m_perr_dummy = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    // Reference model state: bits of the frame in progress, words held by the buffer, drops.
    logic       bits[$];
    logic [8:0] exp_q[$];
    int         exp_drop = 0;
    logic [7:0] mw;
    logic       mp;

    hd08_bit_deser #(.DROP_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_bit    (s_bit),
        .s_valid  (s_valid),
        .s_sof    (s_sof),
        .m_x      (m_x),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
`ifdef HD08_DESER_PARITY_EN
        .m_perr   (m_perr),
`endif
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a frame is FLEN valid bits since sof/reset; the buffer is a queue of depth 2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bits.delete();
            exp_q.delete();
            exp_drop = 0;
        end else if (s_valid) begin
            if (s_sof) bits.delete();
            bits.push_back(s_bit);
            if (bits.size() == FLEN) begin
                mw = 8'h00;
                for (int k = 0; k < 8; k++) mw = mw | (8'(bits[k]) << k);
                mp = 1'b0;
`ifdef HD08_DESER_PARITY_EN
                mp = (^mw) ^ bits[8];
`endif
                if (exp_q.size() < 2) exp_q.push_back({mp, mw});
                else if (exp_drop < 255) exp_drop++;
                bits.delete();
            end
        end
    end

    // Monitor: compares outputs to the head of the expected queue, pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (exp_q.size() != 0) begin
                check("m_x", 32'(m_x), 32'(exp_q[0][7:0]));
`ifdef HD08_DESER_PARITY_EN
                check("m_perr", 32'(m_perr), 32'(exp_q[0][8]));
`endif
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic sof, input logic rdy);
        s_valid = v;
        s_bit   = b;
        s_sof   = sof;
        m_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic par, input logic sof, input logic rdy, input int gaps);
        for (int k = 0; k < FLEN; k++) begin
            repeat ($urandom_range(0, gaps)) drive(1'b0, 1'b0, 1'b0, rdy);
            drive(1'b1, (k < 8) ? w[k] : par, sof && (k == 0), rdy);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_x", 32'(m_x), 32'h00);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Bits 1,0,1,1,0,0,0,1 -> 8'h8D, valid for exactly one cycle.
        send_word(8'h8D, ^8'h8D, 1'b1, 1'b1, 0);
        check("t1_valid", 32'(m_valid), 32'd1);
        check("t1_x", 32'(m_x), 32'h8D);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_fall", 32'(m_valid), 32'd0);

        // Overflow: third word dropped, first held stable.
        send_word(8'h01, ^8'h01, 1'b1, 1'b0, 0);
        send_word(8'h02, ^8'h02, 1'b1, 1'b0, 0);
        send_word(8'h03, ^8'h03, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_hold_x", 32'(m_x), 32'h01);
        check("t2_drop", 32'(drop_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_second", 32'(m_x), 32'h02);
        check("t2_second_vld", 32'(m_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_empty", 32'(m_valid), 32'd0);

        // Partial word abandoned by sof.
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, k == 0, 1'b1);
        send_word(8'hA5, ^8'hA5, 1'b1, 1'b1, 0);
        check("t3_x", 32'(m_x), 32'hA5);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Gaps inside a word.
        send_word(8'h3C, ^8'h3C, 1'b1, 1'b1, 3);
        check("t4_x", 32'(m_x), 32'h3C);
        check("t4_vld", 32'(m_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Async reset mid-frame with OUT and SKID full.
        send_word(8'h11, ^8'h11, 1'b1, 1'b0, 0);
        send_word(8'h22, ^8'h22, 1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, k == 0, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_vld", 32'(m_valid), 32'd0);
        check("t5_rst_x", 32'(m_x), 32'h00);
        check("t5_rst_drop", 32'(drop_cnt), 32'd0);
`ifdef HD08_DESER_PARITY_EN
        check("t5_rst_perr", 32'(m_perr), 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h5A, ^8'h5A, 1'b0, 1'b1, 0);
        check("t5_after_x", 32'(m_x), 32'h5A);
        check("t5_after_vld", 32'(m_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef HD08_DESER_PARITY_EN
        send_word(8'h07, 1'b1, 1'b1, 1'b1, 0);
        check("t6_x0", 32'(m_x), 32'h07);
        check("t6_perr0", 32'(m_perr), 32'd0);
        send_word(8'h07, 1'b0, 1'b1, 1'b1, 0);
        check("t6_x1", 32'(m_x), 32'h07);
        check("t6_perr1", 32'(m_perr), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic: bursty valid, occasional sof, random backpressure.
        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);

        // Drain: everything the model still holds must come out.
        repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_vld", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

`ifndef HD08_DESER_PARITY_EN
    // Parity-less build: keep the unused flag observed.
    always @(posedge clk) if (m_perr_dummy) $display("unexpected parity flag");
`endif

endmodule
